// File: rtl/uart_cal_pkg.sv
// Shared constants for the UART calculator path:
// opcodes, ASCII codes, parser states and error codes.
package uart_cal_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  localparam logic [7:0] ASC_0     = 8'h30;
  localparam logic [7:0] ASC_9     = 8'h39;
  localparam logic [7:0] ASC_SP    = 8'h20;
  localparam logic [7:0] ASC_EQ    = 8'h3D;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_PLUS  = 8'h2B;
  localparam logic [7:0] ASC_MINUS = 8'h2D;
  localparam logic [7:0] ASC_MUL   = 8'h2A;
  localparam logic [7:0] ASC_DIV   = 8'h2F;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CHAR = 2'd1;
  localparam logic [1:0] ERR_OVF  = 2'd2;
  localparam logic [1:0] ERR_OVR  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_OPA  = 3'd1,
    ST_OPB  = 3'd2,
    ST_HOLD = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  // Map an operator character to its opcode.
  // Non-operators map to OP_ADD; callers
  // qualify with their own operator test.
  function automatic logic [1:0] op_of(
    input logic [7:0] c
  );
    logic [1:0] r;
    r = OP_ADD;
    if (c == ASC_MINUS) r = OP_SUB;
    if (c == ASC_MUL)   r = OP_MUL;
    if (c == ASC_DIV)   r = OP_DIV;
    return r;
  endfunction

endpackage

// File: rtl/dec_digit_acc.sv
// Decimal digit accumulator: value = value*10 + digit,
// with a digit counter that saturates at MAX_DIGITS.
module dec_digit_acc #(
  parameter int DW         = 14,
  parameter int MAX_DIGITS = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          load_digit,
  input  logic [3:0]    digit,
  output logic [DW-1:0] value,
  output logic          full
);

  localparam int CW = $clog2(MAX_DIGITS + 1);

  logic [DW-1:0] r_value;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] w_digit_ext;
  logic [DW-1:0] w_acc_next;

  assign w_digit_ext = {{(DW-4){1'b0}}, digit};
  assign w_acc_next  = (r_value << 3)
                     + (r_value << 1)
                     + w_digit_ext;

  // clear+load starts a fresh operand with
  // this digit; load alone appends a digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value <= '0;
      r_cnt   <= '0;
    end else if (clear) begin
      r_value <= load_digit ? w_digit_ext : '0;
      r_cnt   <= load_digit ? CW'(1) : '0;
    end else if (load_digit && !full) begin
      r_value <= w_acc_next;
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  assign value = r_value;
  assign full  = (r_cnt == CW'(MAX_DIGITS));

endmodule

// File: rtl/uart_cmd_parser.sv
// ASCII infix command parser "<A><op><B><term>"
// feeding the calculator core over valid/ready.
module uart_cmd_parser
  import uart_cal_pkg::*;
#(
  parameter int MAX_DIGITS = 4,
  parameter int DW         = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  input  logic          cmd_ready,
  output logic          cmd_valid,
  output logic [DW-1:0] op_a,
  output logic [DW-1:0] op_b,
  output logic [1:0]    op_code,
  output logic          err_valid,
  output logic [1:0]    err_code
);

  state_t r_state;
  state_t w_state_n;

  logic       r_rx_valid_d;
  logic       r_b_has;
  logic [1:0] r_op_code;
  logic       r_err_valid;
  logic [1:0] r_err_code;

  logic w_stb;
  logic w_dig;
  logic w_sp;
  logic w_op;
  logic w_term;
  logic w_bad;

  logic w_a_clr;
  logic w_a_ld;
  logic w_b_clr;
  logic w_b_ld;
  logic w_op_ld;
  logic w_err_set;
  logic [1:0] w_err_code_n;

  logic w_a_full;
  logic w_b_full;
  logic [DW-1:0] w_a_val;
  logic [DW-1:0] w_b_val;

  assign w_stb  = rx_valid & ~r_rx_valid_d;
  assign w_dig  = (rx_data >= ASC_0)
                & (rx_data <= ASC_9);
  assign w_sp   = (rx_data == ASC_SP);
  assign w_op   = (rx_data == ASC_PLUS)
                | (rx_data == ASC_MINUS)
                | (rx_data == ASC_MUL)
                | (rx_data == ASC_DIV);
  assign w_term = (rx_data == ASC_EQ)
                | (rx_data == ASC_CR);
  assign w_bad  = ~(w_dig | w_sp | w_op | w_term);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_n;
  end

  // Next state. An error on a terminator byte
  // already ends the line, so it goes to IDLE.
  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_stb) begin
          if (w_dig)           w_state_n = ST_OPA;
          else if (w_op|w_bad) w_state_n = ST_ERR;
        end
      end
      ST_OPA: begin
        if (w_stb) begin
          if (w_dig && w_a_full) w_state_n = ST_ERR;
          else if (w_op)         w_state_n = ST_OPB;
          else if (w_term)       w_state_n = ST_IDLE;
          else if (w_bad)        w_state_n = ST_ERR;
        end
      end
      ST_OPB: begin
        if (w_stb) begin
          if (w_dig && w_b_full) w_state_n = ST_ERR;
          else if (w_term)
            w_state_n = r_b_has ? ST_HOLD : ST_IDLE;
          else if (w_op|w_bad)   w_state_n = ST_ERR;
        end
      end
      ST_HOLD: begin
        if (cmd_ready) w_state_n = ST_IDLE;
      end
      ST_ERR: begin
        if (w_stb && w_term) w_state_n = ST_IDLE;
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  // Datapath controls and error requests.
  always_comb begin
    w_a_clr      = 1'b0;
    w_a_ld       = 1'b0;
    w_b_clr      = 1'b0;
    w_b_ld       = 1'b0;
    w_op_ld      = 1'b0;
    w_err_set    = 1'b0;
    w_err_code_n = ERR_NONE;
    cmd_valid    = (r_state == ST_HOLD);
    unique case (r_state)
      ST_IDLE: begin
        if (w_stb && w_dig) begin
          w_a_clr = 1'b1;
          w_a_ld  = 1'b1;
        end else if (w_stb && (w_op | w_bad)) begin
          w_err_set    = 1'b1;
          w_err_code_n = ERR_CHAR;
        end
      end
      ST_OPA: begin
        if (w_stb && w_dig) begin
          if (w_a_full) begin
            w_err_set    = 1'b1;
            w_err_code_n = ERR_OVF;
          end else begin
            w_a_ld = 1'b1;
          end
        end else if (w_stb && w_op) begin
          w_op_ld = 1'b1;
          w_b_clr = 1'b1;
        end else if (w_stb && (w_term | w_bad)) begin
          w_err_set    = 1'b1;
          w_err_code_n = ERR_CHAR;
        end
      end
      ST_OPB: begin
        if (w_stb && w_dig) begin
          if (w_b_full) begin
            w_err_set    = 1'b1;
            w_err_code_n = ERR_OVF;
          end else begin
            w_b_ld = 1'b1;
          end
        end else if (w_stb && w_term && !r_b_has) begin
          w_err_set    = 1'b1;
          w_err_code_n = ERR_CHAR;
        end else if (w_stb && (w_op | w_bad)) begin
          w_err_set    = 1'b1;
          w_err_code_n = ERR_CHAR;
        end
      end
      ST_HOLD: begin
        if (w_stb) begin
          w_err_set    = 1'b1;
          w_err_code_n = ERR_OVR;
        end
      end
      ST_ERR: begin
        w_err_set = 1'b0;
      end
      default: begin
        w_err_set = 1'b0;
      end
    endcase
  end

  // Edge detector, opcode latch, B-seen flag
  // and the registered error strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_valid_d <= 1'b0;
      r_op_code    <= OP_ADD;
      r_b_has      <= 1'b0;
      r_err_valid  <= 1'b0;
      r_err_code   <= ERR_NONE;
    end else begin
      r_rx_valid_d <= rx_valid;
      r_err_valid  <= w_err_set;
      if (w_op_ld) r_op_code <= op_of(rx_data);
      if (w_b_clr)     r_b_has <= 1'b0;
      else if (w_b_ld) r_b_has <= 1'b1;
      if (w_err_set) r_err_code <= w_err_code_n;
    end
  end

  dec_digit_acc #(
    .DW         (DW),
    .MAX_DIGITS (MAX_DIGITS)
  ) u_acc_a (
    .clk        (clk),
    .rst        (rst),
    .clear      (w_a_clr),
    .load_digit (w_a_ld),
    .digit      (rx_data[3:0]),
    .value      (w_a_val),
    .full       (w_a_full)
  );

  dec_digit_acc #(
    .DW         (DW),
    .MAX_DIGITS (MAX_DIGITS)
  ) u_acc_b (
    .clk        (clk),
    .rst        (rst),
    .clear      (w_b_clr),
    .load_digit (w_b_ld),
    .digit      (rx_data[3:0]),
    .value      (w_b_val),
    .full       (w_b_full)
  );

  assign op_a      = w_a_val;
  assign op_b      = w_b_val;
  assign op_code   = r_op_code;
  assign err_valid = r_err_valid;
  assign err_code  = r_err_code;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: a vector
// table of command lines plus multi-cycle cases.
module tb_uart_cmd_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        cmd_ready;
  logic        cmd_valid;
  logic [13:0] op_a;
  logic [13:0] op_b;
  logic [1:0]  op_code;
  logic        err_valid;
  logic [1:0]  err_code;

  uart_cmd_parser #(
    .MAX_DIGITS (4),
    .DW         (14)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .cmd_ready (cmd_ready),
    .cmd_valid (cmd_valid),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_code   (op_code),
    .err_valid (err_valid),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit [95:0]  txt;
    int         n_cmd;
    int         n_err;
    logic [13:0] a;
    logic [13:0] b;
    logic [1:0] op;
    logic [1:0] ec;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  int n_chk = 0;
  int n_fail = 0;

  int m_cmd = 0;
  int m_err = 0;
  logic [13:0] m_a;
  logic [13:0] m_b;
  logic [1:0]  m_op;
  logic [1:0]  m_ec;

  // Record accepted commands and error strobes.
  always @(negedge clk) begin
    if (cmd_valid && cmd_ready) begin
      m_cmd = m_cmd + 1;
      m_a   = op_a;
      m_b   = op_b;
      m_op  = op_code;
    end
    if (err_valid) begin
      m_err = m_err + 1;
      m_ec  = err_code;
    end
  end

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b,
                      input int hi);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    repeat (hi) @(posedge clk);
    #1;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic send_str(input bit [95:0] s);
    for (int i = 11; i >= 0; i--) begin
      if (s[i*8 +: 8] != 8'h00)
        send(s[i*8 +: 8], 16);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " cmd_valid"}, int'(cmd_valid), 0);
    chk({tag, " op_a"},      int'(op_a),      0);
    chk({tag, " op_b"},      int'(op_b),      0);
    chk({tag, " op_code"},   int'(op_code),   0);
    chk({tag, " err_valid"}, int'(err_valid), 0);
    chk({tag, " err_code"},  int'(err_code),  0);
  endtask

  int c0;
  int e0;
  int bad;

  initial begin
    vecs[0]  = '{"12+34=",       1, 0, 14'd12,   14'd34, 2'd0, 2'd0};
    vecs[1]  = '{"12345+1=3-1=", 1, 1, 14'd3,    14'd1,  2'd1, 2'd2};
    vecs[2]  = '{"5+=A=8/ 2=",   1, 2, 14'd8,    14'd2,  2'd3, 2'd1};
    vecs[3]  = '{"9999-0=",      1, 0, 14'd9999, 14'd0,  2'd1, 2'd0};
    vecs[4]  = '{"100*25\015",   1, 0, 14'd100,  14'd25, 2'd2, 2'd0};
    vecs[5]  = '{"7/0=",         1, 0, 14'd7,    14'd0,  2'd3, 2'd0};
    vecs[6]  = '{" 1 + 2 =",     1, 0, 14'd1,    14'd2,  2'd0, 2'd0};
    vecs[7]  = '{"+5=",          0, 1, 14'd0,    14'd0,  2'd0, 2'd1};
    vecs[8]  = '{"12=4+4=",      1, 1, 14'd4,    14'd4,  2'd0, 2'd1};
    vecs[9]  = '{"1+12345=",     0, 1, 14'd0,    14'd0,  2'd0, 2'd2};
    vecs[10] = '{"1++2=",        0, 1, 14'd0,    14'd0,  2'd0, 2'd1};

    rst       = 1'b1;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    cmd_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);

    for (int v = 0; v < NV; v++) begin
      c0 = m_cmd;
      e0 = m_err;
      send_str(vecs[v].txt);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d ncmd", v),
          m_cmd - c0, vecs[v].n_cmd);
      chk($sformatf("v%0d nerr", v),
          m_err - e0, vecs[v].n_err);
      chk($sformatf("v%0d idle", v),
          int'(cmd_valid), 0);
      if (vecs[v].n_cmd > 0) begin
        chk($sformatf("v%0d op_a", v),
            int'(m_a), int'(vecs[v].a));
        chk($sformatf("v%0d op_b", v),
            int'(m_b), int'(vecs[v].b));
        chk($sformatf("v%0d op_code", v),
            int'(m_op), int'(vecs[v].op));
      end
      if (vecs[v].n_err > 0) begin
        chk($sformatf("v%0d err_code", v),
            int'(m_ec), int'(vecs[v].ec));
      end
    end

    // Hold with cmd_ready low, overrun byte,
    // then release.
    cmd_ready = 1'b0;
    c0 = m_cmd;
    e0 = m_err;
    send_str("9999*2");
    @(posedge clk);
    #1;
    rx_data  = 8'h0D;
    rx_valid = 1'b1;
    @(negedge clk);
    chk("hold pre", int'(cmd_valid), 0);
    @(negedge clk);
    chk("hold lat", int'(cmd_valid), 1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!(cmd_valid && op_a == 14'd9999 &&
            op_b == 14'd2 && op_code == 2'd2))
        bad++;
    end
    chk("hold stable", bad, 0);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    chk("hold no err", m_err - e0, 0);

    @(posedge clk);
    #1;
    rx_data  = 8'h37;
    rx_valid = 1'b1;
    @(negedge clk);
    chk("ovr pre", int'(err_valid), 0);
    @(negedge clk);
    chk("ovr strobe", int'(err_valid), 1);
    chk("ovr code", int'(err_code), 3);
    @(negedge clk);
    chk("ovr one cyc", int'(err_valid), 0);
    repeat (10) @(posedge clk);
    #1;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("ovr nerr", m_err - e0, 1);
    chk("ovr hold", int'(cmd_valid), 1);
    chk("ovr op_a", int'(op_a), 9999);
    chk("ovr op_b", int'(op_b), 2);
    chk("ovr op_code", int'(op_code), 2);
    chk("ovr no cmd", m_cmd - c0, 0);

    @(posedge clk);
    #1;
    cmd_ready = 1'b1;
    @(negedge clk);
    chk("rel same cyc", int'(cmd_valid), 1);
    @(posedge clk);
    #1;
    chk("rel drop", int'(cmd_valid), 0);
    chk("rel ncmd", m_cmd - c0, 1);

    // One long rx_valid pulse is one byte.
    c0 = m_cmd;
    e0 = m_err;
    send(8'h37, 40);
    send_str("+1=");
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("long ncmd", m_cmd - c0, 1);
    chk("long op_a", int'(m_a), 7);
    chk("long op_b", int'(m_b), 1);
    chk("long nerr", m_err - e0, 0);

    // Blank line.
    c0 = m_cmd;
    e0 = m_err;
    send_str("=");
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("blank ncmd", m_cmd - c0, 0);
    chk("blank nerr", m_err - e0, 0);

    // Reset in the middle of a command.
    send_str("45+");
    @(negedge clk);
    chk("pre-rst op_a", int'(op_a), 45);
    chk("pre-rst ecode", int'(err_code), 3);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    c0 = m_cmd;
    e0 = m_err;
    send_str("1+1=");
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("post-rst ncmd", m_cmd - c0, 1);
    chk("post-rst op_a", int'(m_a), 1);
    chk("post-rst op_b", int'(m_b), 1);
    chk("post-rst op", int'(m_op), 0);
    chk("post-rst nerr", m_err - e0, 0);

    $display("[TB] %0d tests run, %0d failed",
             n_chk, n_fail);
    $finish;
  end

endmodule
